// File: rtl/avg_sequencer.sv
// avg_sequencer: issues clrld/addld/add/div2/disp stream to average n operands by 2^k, with operand handshake
module avg_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       n_ops,
    input  logic [1:0]       n_shift,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    output logic             op_ready,
    output logic [2:0]       instr,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_FIRST, S_LOAD_NEXT, S_ADD, S_SHIFT, S_DISP, S_FIN
    } state_t;

    state_t           r_state, w_next;
    logic [3:0]       r_cnt, w_cnt_n;
    logic [1:0]       r_sh, w_sh_n;
    logic [2:0]       r_instr, w_instr_n;
    logic             r_done, r_v1;
    logic [WIDTH-1:0] r_d1, r_data;
    logic             w_xfer;

    assign op_ready = (r_state == S_LOAD_FIRST) || (r_state == S_LOAD_NEXT);
    assign w_xfer   = op_valid && op_ready;
    assign busy     = r_state != S_IDLE;
    assign done     = r_done;
    assign instr    = r_instr;
    assign data_out = r_data;

    always_comb begin
        w_next    = r_state;
        w_instr_n = 3'b111;
        w_cnt_n   = r_cnt;
        w_sh_n    = r_sh;
        case (r_state)
            S_IDLE: if (start && n_ops != 4'd0) begin
                w_next  = S_LOAD_FIRST;
                w_cnt_n = n_ops;
                w_sh_n  = n_shift;
            end
            S_LOAD_FIRST, S_LOAD_NEXT: if (w_xfer) begin
                w_instr_n = (r_state == S_LOAD_FIRST) ? 3'b000 : 3'b001;
                w_cnt_n   = r_cnt - 4'd1;
                w_next    = (r_cnt == 4'd1) ? S_ADD : S_LOAD_NEXT;
            end
            S_ADD: begin
                w_instr_n = 3'b010;
                w_next    = (r_sh != 2'd0) ? S_SHIFT : S_DISP;
            end
            S_SHIFT: begin
                w_instr_n = 3'b011;
                w_sh_n    = r_sh - 2'd1;
                w_next    = (r_sh == 2'd1) ? S_DISP : S_SHIFT;
            end
            S_DISP: begin
                w_instr_n = 3'b100;
                w_next    = S_FIN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_instr <= 3'b111;
            r_done  <= 1'b0;
            r_v1    <= 1'b0;
            r_d1    <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_n;
            r_sh    <= w_sh_n;
            r_instr <= w_instr_n;
            r_done  <= r_state == S_FIN;
            // second stage lines the operand up with the decoder's registered load code
            r_v1    <= w_xfer;
            if (w_xfer) r_d1 <= op_data;
            if (r_v1) r_data <= r_d1;
        end
    end
endmodule

// File: tb/tb_avg_sequencer.sv
// tb_avg_sequencer: table-driven sequences plus hand-written reset/ignore/back-to-back cases
module tb_avg_sequencer;
    logic       clk = 1'b0;
    logic       rst, start, op_valid;
    logic [3:0] n_ops;
    logic [1:0] n_shift;
    logic [7:0] op_data;
    logic       op_ready, busy, done;
    logic [2:0] instr;
    logic [7:0] data_out;

    avg_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .n_ops(n_ops), .n_shift(n_shift),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready), .instr(instr),
        .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n; int k; int si; int sl; bit noise; int exp_done;
    } vec_t;

    int         errors = 0, checks = 0;
    logic [7:0] cur = 8'd0;
    int         obs_instr[64];
    logic [7:0] obs_dout[64];
    int         done_cyc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // si = operand index preceded by sl stall cycles (-1: none)
    task automatic run_seq(input int n, input int k, input int si, input int sl, input bit noise);
        bit         vq[32];
        logic [7:0] dq[32];
        int         len = 0;
        int         ei;
        bit         first = 1'b1;
        for (int j = 0; j < n; j++) begin
            if (j == si)
                for (int s = 0; s < sl; s++) begin
                    vq[len] = 1'b0; dq[len] = 8'hEE; len++;
                end
            vq[len] = 1'b1;
            dq[len] = (j == 0) ? 8'd8 : (j == 1) ? 8'd4 : 8'(j * 13 + 5);
            len++;
        end
        start = 1'b1; n_ops = 4'(n); n_shift = 2'(k); op_valid = 1'b0;
        @(posedge clk);
        done_cyc = 0;
        for (int c = 1; c <= len + k + 4; c++) begin
            #1;
            start = noise && c >= 2 && c <= len + k + 3;
            if (noise) begin n_ops = 4'($urandom); n_shift = 2'($urandom); end
            op_valid = (c <= len) ? vq[c-1] : (noise ? 1'($urandom) : 1'b0);
            op_data  = (c <= len) ? dq[c-1] : 8'($urandom);
            @(negedge clk);
            if (c >= 2 && c <= len + 1) begin
                ei = vq[c-2] ? (first ? 0 : 1) : 7;
                if (vq[c-2]) first = 1'b0;
            end else if (c == len + 2) ei = 2;
            else if (c > len + 2 && c <= len + k + 2) ei = 3;
            else if (c == len + k + 3) ei = 4;
            else ei = 7;
            if (c >= 3 && c - 2 <= len && vq[c-3]) cur = dq[c-3];
            chk($sformatf("instr n%0d k%0d c%0d", n, k, c), int'(instr), ei);
            chk($sformatf("busy n%0d k%0d c%0d", n, k, c), int'(busy), int'(c <= len + k + 3));
            chk($sformatf("op_ready n%0d k%0d c%0d", n, k, c), int'(op_ready), int'(c <= len));
            chk($sformatf("done n%0d k%0d c%0d", n, k, c), int'(done), int'(c == len + k + 4));
            chk($sformatf("data_out n%0d k%0d c%0d", n, k, c), int'(data_out), int'(cur));
            obs_instr[c] = int'(instr);
            obs_dout[c]  = data_out;
            if (done && done_cyc == 0) done_cyc = c;
            if (c < len + k + 4) @(posedge clk);
        end
    endtask

    initial begin
        vec_t tbl[6];
        int   exp5[5];
        tbl[0] = '{n: 2,  k: 1, si: -1, sl: 0, noise: 1'b0, exp_done: 7};
        tbl[1] = '{n: 1,  k: 0, si: -1, sl: 0, noise: 1'b0, exp_done: 5};
        tbl[2] = '{n: 15, k: 3, si: -1, sl: 0, noise: 1'b0, exp_done: 22};
        tbl[3] = '{n: 3,  k: 2, si: 1,  sl: 3, noise: 1'b0, exp_done: 12};
        tbl[4] = '{n: 4,  k: 0, si: 0,  sl: 2, noise: 1'b1, exp_done: 10};
        tbl[5] = '{n: 5,  k: 3, si: 4,  sl: 1, noise: 1'b1, exp_done: 13};
        exp5 = '{0, 1, 2, 3, 4};

        rst = 1'b1; start = 1'b1; n_ops = 4'd3; n_shift = 2'd1; op_valid = 1'b1; op_data = 8'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset instr", int'(instr), 7);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset op_ready", int'(op_ready), 0);
        chk("reset data_out", int'(data_out), 0);
        rst = 1'b0; start = 1'b0; op_valid = 1'b0;

        start = 1'b1; n_ops = 4'd0;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("nops0 busy", int'(busy), 0);
        chk("nops0 op_ready", int'(op_ready), 0);

        // consecutive runs start in the previous done cycle (back-to-back)
        for (int i = 0; i < 6; i++) begin
            run_seq(tbl[i].n, tbl[i].k, tbl[i].si, tbl[i].sl, tbl[i].noise);
            chk($sformatf("done cycle vec%0d", i), done_cyc, tbl[i].exp_done);
            if (i == 0) begin
                for (int c = 2; c <= 6; c++) chk($sformatf("hand instr c%0d", c), obs_instr[c], exp5[c-2]);
                chk("hand data_out c3", int'(obs_dout[3]), 8);
                chk("hand data_out c4", int'(obs_dout[4]), 4);
            end
        end

        @(posedge clk); #1;
        start = 1'b1; n_ops = 4'd2; n_shift = 2'd3; op_valid = 1'b1; op_data = 8'd20;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre-reset instr add", int'(instr), 2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        cur = 8'd0;
        chk("midreset instr", int'(instr), 7);
        chk("midreset busy", int'(busy), 0);
        chk("midreset op_ready", int'(op_ready), 0);
        chk("midreset done", int'(done), 0);
        chk("midreset data_out", int'(data_out), 0);
        run_seq(3, 1, -1, 0, 1'b0);
        chk("post-reset done cycle", done_cyc, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/avg_sequencer.md
# avg_sequencer

Program sequencer for the X/Y/Z register + ALU datapath: on a start request, issues the 3-bit instruction stream that accumulates `n_ops` operands and divides the sum by 2^`n_shift`, then displays the result. It sits upstream of the instruction decoder (drives its 3-bit instruction input) and gates operands onto the datapath input bus through a valid/ready handshake, aligned to when the decoder's registered control codes reach X.

## Interface
- `WIDTH`, 8, operand/data bus width
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a new sequence; sampled only while `busy`=0
- `n_ops`  in  4  operand count (1..15), latched at accepted start
- `n_shift`  in  2  number of div2 steps (0..3), latched at accepted start
- `op_valid`  in  1  `op_data` holds a valid operand
- `op_data`  in  WIDTH  operand from source
- `op_ready`  out  1  sequencer can accept an operand this cycle
- `instr`  out  3  registered instruction to decoder
- `data_out`  out  WIDTH  operand presented to X register input
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse at end of sequence

## Operation
- Instruction codes: clrld=000, addld=001, add=010, div2=011, disp=100, NOP=111 (undecoded; decoder holds its last codes).
- Sequence for n operands, k shifts: clrld (op 1), addld (ops 2..n), add, div2 ×k, disp. Total n+k+2 non-NOP instructions.
- States: IDLE, LOAD_FIRST, LOAD_NEXT, ADD, SHIFT, DISP, FIN.
- IDLE: `start`=1 and `n_ops`≠0 -> latch `n_ops`/`n_shift`, go LOAD_FIRST. `start` with `n_ops`=0 ignored (stay IDLE, no `busy`).
- LOAD_FIRST/LOAD_NEXT: `op_ready`=1 (Moore, from state only). Transfer = `op_valid`&`op_ready`. On transfer: next `instr` = clrld (first) or addld (subsequent), decrement remaining count; after last operand go ADD. Without transfer: next `instr`=NOP, stay (stall, any length).
- ADD: next `instr`=add; go SHIFT if k>0 else DISP.
- SHIFT: next `instr`=div2; decrement shift count; go DISP after k-th.
- DISP: next `instr`=disp; go FIN. FIN: next `instr`=NOP, `done` pulses, go IDLE.
- `op_ready`=0 in all non-load states.
- `data_out`: two-stage delay of accepted `op_data`; updates exactly 2 cycles after the transfer edge (aligned with decoder's registered load code), holds otherwise.
- `start` while `busy`=1 ignored; inputs `n_ops`/`n_shift` changes mid-sequence have no effect.
- Reset (any time, incl. mid-sequence): state IDLE, `instr`=NOP, `op_ready`=0, `busy`=0, `done`=0, `data_out`=0, delay stages and counters cleared; pending operands discarded.

## Timing
- `start` sampled at edge 0 -> `busy`=1 and `op_ready`=1 from cycle 1.
- Operand accepted at edge t -> `instr`=clrld/addld during cycle t+1 -> `data_out` valid cycle t+2.
- No stalls: first `instr` in cycle 2, one instruction per cycle, `disp` in cycle n+k+3, `done`=1 and `busy`=0 in cycle n+k+4.
- Each stall cycle in a load state inserts exactly one NOP and delays all later events by one.
- `start` high in the `done` cycle is accepted (back-to-back sequences, no dead cycle beyond FIN).

## Test plan
- Reset: assert `rst` 2 cycles with `start`=1 -> `instr`=111, `busy`=0, `done`=0, `op_ready`=0, `data_out`=0.
- n=2, k=1, `op_valid` always 1, ops 8 and 4 -> `instr` cycles 2..6 = 000,001,010,011,100; `done` cycle 7; `data_out`=8 cycle 3, 4 cycle 4.
- n=1, k=0 -> 000,010,100 in cycles 2..4; `done` cycle 5; n=15, k=3 -> 20 instructions, `done` cycle 22.
- Stall: n=3, k=2, `op_valid` low 3 cycles before second operand -> three 111 between 000 and 001; `done` shifted by 3; `op_ready` stays 1 throughout stall.
- Start while busy and `start` with `n_ops`=0 -> both ignored, sequence unchanged; `start` in `done` cycle -> new `busy` next cycle.
- `rst` asserted during SHIFT -> next cycle IDLE outputs; following start runs full sequence from clrld.
